// File: rtl/tx_frame_builder.sv
// Transmit frame builder: pads host frames to the Ethernet minimum, appends CRC-32 FCS
// when TX_FCS_GEN_EN is defined, and publishes each frame's byte count over req/ack.
module tx_frame_builder #(
  parameter int MIN_LEN     = 60,
  parameter int MAX_LEN     = 1514,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  fifo_wr_data,
  output logic        fifo_wr,
  input  logic        fifo_full,
  output logic [10:0] word_count,
  output logic        word_count_ready,
  input  logic        word_count_ack
);

  // Handshake: word_count is valid and held while word_count_ready=1; the transmitter
  // raises word_count_ack, ready then drops, ack falls, and the next frame may start.

`ifdef TX_FCS_GEN_EN
  localparam int PAD_TARGET = MIN_LEN;
  typedef enum logic [2:0] {S_DATA, S_PAD, S_FCS, S_REQ, S_REL} state_t;
`else
  localparam int PAD_TARGET = MIN_LEN + 4;
  typedef enum logic [2:0] {S_DATA, S_PAD, S_REQ, S_REL} state_t;
`endif

  state_t                 state_q, state_d;
  logic [10:0]            byte_cnt_q, byte_cnt_d;
  logic [10:0]            word_count_q, word_count_d;
  logic                   fifo_wr_q, fifo_wr_d;
  logic [7:0]             fifo_wr_data_q, fifo_wr_data_d;
  logic                   ready_q, ready_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic                   accept;

`ifdef TX_FCS_GEN_EN
  logic [31:0] crc_q, crc_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [31:0] fcs_word;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0000_0000);
    end
    return r;
  endfunction

  assign fcs_word = ~crc_q;
`endif

  assign ack_s   = ack_sync_q[SYNC_STAGES-1];
  assign s_ready = (state_q == S_DATA) && !fifo_full && !rst;
  assign accept  = s_valid && s_ready;

  assign fifo_wr          = fifo_wr_q;
  assign fifo_wr_data     = fifo_wr_data_q;
  assign word_count       = word_count_q;
  assign word_count_ready = ready_q;

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    word_count_d   = word_count_q;
    fifo_wr_d      = 1'b0;
    fifo_wr_data_d = fifo_wr_data_q;
`ifdef TX_FCS_GEN_EN
    crc_d          = crc_q;
    fcs_idx_d      = fcs_idx_q;
`endif
    // Ready rises one cycle after the last byte write and drops as soon as ack is seen.
    ready_d        = (state_q == S_REQ) && !ack_s;

    unique case (state_q)
      S_DATA: begin
        if (accept) begin
          if (byte_cnt_q < 11'(MAX_LEN)) begin
            fifo_wr_d      = 1'b1;
            fifo_wr_data_d = s_data;
            byte_cnt_d     = byte_cnt_q + 11'd1;
`ifdef TX_FCS_GEN_EN
            crc_d          = crc_byte(crc_q, s_data);
`endif
          end
          if (s_last) begin
            if (byte_cnt_d < 11'(PAD_TARGET)) begin
              state_d = S_PAD;
            end else begin
`ifdef TX_FCS_GEN_EN
              state_d = S_FCS;
`else
              state_d      = S_REQ;
              word_count_d = byte_cnt_d;
`endif
            end
          end
        end
      end
      S_PAD: begin
        if (!fifo_full) begin
          fifo_wr_d      = 1'b1;
          fifo_wr_data_d = 8'h00;
          byte_cnt_d     = byte_cnt_q + 11'd1;
`ifdef TX_FCS_GEN_EN
          crc_d          = crc_byte(crc_q, 8'h00);
`endif
          if (byte_cnt_d == 11'(PAD_TARGET)) begin
`ifdef TX_FCS_GEN_EN
            state_d = S_FCS;
`else
            state_d      = S_REQ;
            word_count_d = byte_cnt_d;
`endif
          end
        end
      end
`ifdef TX_FCS_GEN_EN
      S_FCS: begin
        // CRC is frozen here; the complemented value goes out least significant byte first.
        if (!fifo_full) begin
          fifo_wr_d      = 1'b1;
          fifo_wr_data_d = fcs_word[{fcs_idx_q, 3'b000} +: 8];
          byte_cnt_d     = byte_cnt_q + 11'd1;
          fcs_idx_d      = fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            state_d      = S_REQ;
            word_count_d = byte_cnt_d;
          end
        end
      end
`endif
      S_REQ: begin
        if (ack_s) state_d = S_REL;
      end
      S_REL: begin
        if (!ack_s) begin
          byte_cnt_d = 11'd0;
`ifdef TX_FCS_GEN_EN
          crc_d      = 32'hFFFF_FFFF;
`endif
          state_d    = S_DATA;
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_DATA;
      byte_cnt_q     <= 11'd0;
      word_count_q   <= 11'd0;
      fifo_wr_q      <= 1'b0;
      fifo_wr_data_q <= 8'h00;
      ready_q        <= 1'b0;
      ack_sync_q     <= '0;
`ifdef TX_FCS_GEN_EN
      crc_q          <= 32'hFFFF_FFFF;
      fcs_idx_q      <= 2'd0;
`endif
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      word_count_q   <= word_count_d;
      fifo_wr_q      <= fifo_wr_d;
      fifo_wr_data_q <= fifo_wr_data_d;
      ready_q        <= ready_d;
      ack_sync_q     <= {ack_sync_q[SYNC_STAGES-2:0], word_count_ack};
`ifdef TX_FCS_GEN_EN
      crc_q          <= crc_d;
      fcs_idx_q      <= fcs_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_frame_builder.sv
// Bench for tx_frame_builder: random host frames against a frame-level reference model,
// FIFO scoreboard, req/ack transmitter model, stall and mid-frame reset scenarios.
module tb_tx_frame_builder;

  localparam int MIN_LEN     = 60;
  localparam int MAX_LEN     = 1514;
  localparam int SYNC_STAGES = 2;
`ifdef TX_FCS_GEN_EN
  localparam int PAD_TARGET = MIN_LEN;
  localparam bit FCS_EN     = 1'b1;
`else
  localparam int PAD_TARGET = MIN_LEN + 4;
  localparam bit FCS_EN     = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  fifo_wr_data;
  logic        fifo_wr;
  logic        fifo_full;
  logic [10:0] word_count;
  logic        word_count_ready;
  logic        word_count_ack;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_frame[$];
  logic [7:0] payload[$];
  logic [7:0] saved_payload[$];
  bit         stall_en = 1'b0;
  logic       full_at_edge = 1'b0;
  int         stall_viol = 0;
  int         exp_wc;

  tx_frame_builder #(
    .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .fifo_wr_data(fifo_wr_data), .fifo_wr(fifo_wr),
    .fifo_full(fifo_full), .word_count(word_count),
    .word_count_ready(word_count_ready), .word_count_ack(word_count_ack)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // fifo_full pulses high one cycle in three while stall_en is set
  initial begin
    int cyc;
    cyc = 0;
    fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      fifo_full = stall_en && (cyc % 3 == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = r[0] ^ d[i] ? (r >> 1) ^ 32'hEDB88320 : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] got_residue();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (got_frame[i]) c = crc_step(c, got_frame[i]);
    return c;
  endfunction

  // scoreboard: every FIFO write is matched against the model's expected byte stream
  always @(posedge clk) full_at_edge <= fifo_full;

  always @(negedge clk) begin
    if (fifo_wr) begin
      if (full_at_edge) stall_viol++;
      got_frame.push_back(fifo_wr_data);
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("fifo_byte", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
    end
  end

  // reference model: truncate to MAX_LEN, zero-pad to target, append complemented CRC
  task automatic build_frame(input int n, input bit reuse);
    logic [7:0]  f[$];
    logic [31:0] c;
    int          kept;
    if (!reuse) begin
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
    end
    kept = (n > MAX_LEN) ? MAX_LEN : n;
    for (int i = 0; i < kept; i++) f.push_back(payload[i]);
    while (f.size() < PAD_TARGET) f.push_back(8'h00);
    if (FCS_EN) begin
      c = 32'hFFFF_FFFF;
      foreach (f[i]) c = crc_step(c, f[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
    end
    foreach (f[i]) exp_q.push_back(f[i]);
    exp_wc = f.size();
    got_frame.delete();
  endtask

  // driver: host byte stream with occasional idle gaps
  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      int waitc;
      bit acc;
      waitc = 0;
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = payload[i];
      s_last  = (i == n - 1);
      #4 acc = s_ready;
      while (!acc && waitc < 200) begin
        @(negedge clk);
        #4 acc = s_ready;
        waitc++;
      end
      if (!acc) begin
        chk("s_ready_timeout", 32'(acc), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // transmitter model: 4-phase req/ack with randomized response delays
  task automatic handshake();
    int c;
    c = 0;
    while (!word_count_ready && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("ready_rise", 32'(word_count_ready), 32'd1);
    if (!word_count_ready) return;
    stall_en = 1'b0;
    chk("ready_after_last_write", 32'(exp_q.size()), 32'd0);
    chk("no_write_in_req", 32'(fifo_wr), 32'd0);
    chk("word_count", 32'(word_count), 32'(exp_wc));
    chk("frame_len", 32'(got_frame.size()), 32'(exp_wc));
    if (FCS_EN) chk("fcs_residue", got_residue(), 32'hDEBB20E3);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    chk("ready_hold", 32'(word_count_ready), 32'd1);
    chk("s_ready_in_req", 32'(s_ready), 32'd0);
    word_count_ack = 1'b1;
    c = 0;
    while (word_count_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("ready_drop_in_time", 32'((c <= SYNC_STAGES + 1) && !word_count_ready), 32'd1);
    chk("word_count_stable", 32'(word_count), 32'(exp_wc));
    repeat ($urandom_range(1, 3)) @(negedge clk);
    chk("s_ready_while_ack", 32'(s_ready), 32'd0);
    word_count_ack = 1'b0;
    @(negedge clk);
    chk("s_ready_ack_falling", 32'(s_ready), 32'd0);
    c = 0;
    while (!s_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("s_ready_return", 32'(s_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_fifo_wr"}, 32'(fifo_wr), 32'd0);
    chk({tag, "_fifo_wr_data"}, 32'(fifo_wr_data), 32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    chk({tag, "_ready"}, 32'(word_count_ready), 32'd0);
  endtask

  task automatic run_frame(input int n);
    build_frame(n, 1'b0);
    send_frame(n);
    handshake();
  endtask

  initial begin
    int lens[4];
    rst = 1'b1;
    s_data = 8'h00;
    s_valid = 1'b0;
    s_last = 1'b0;
    word_count_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // short frame that needs padding
    run_frame(14);
    saved_payload = payload;
    // long enough that no padding is needed
    run_frame(100);
    // oversize frame: bytes past MAX_LEN are accepted but dropped
    run_frame(1600);

    // same bytes as the first frame, with periodic fifo_full stalls
    payload = saved_payload;
    build_frame(14, 1'b1);
    stall_viol = 0;
    stall_en = 1'b1;
    send_frame(14);
    handshake();
    chk("stall_no_write", 32'(stall_viol), 32'd0);

    // length boundaries and back-to-back frames
    lens[0] = 1;
    lens[1] = PAD_TARGET - 1;
    lens[2] = PAD_TARGET;
    lens[3] = MAX_LEN;
    foreach (lens[i]) run_frame(lens[i]);
    run_frame($urandom_range(2, 80));
    run_frame($urandom_range(61, 200));

    // reset while padding abandons the frame
    build_frame(10, 1'b0);
    send_frame(10);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midpad_reset");
    rst = 1'b0;
    @(negedge clk);
    got_frame.delete();
    run_frame(60);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
